// File: rtl/id_hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// id_hazard_ctrl_pkg
// Shared pipeline constants for the decode-stage hazard controller.
//   - Control bundle widths (WB/MEM/EX) and the register specifier width.
//   - Bit position of MemRead inside the MEM control bundle.
//   - Hazard FSM state encodings (plain localparams plus a matching enum for
//     debug viewing).
// Optional feature macro used by the top: HAZ_STATS_EN.
// -----------------------------------------------------------------------------
package id_hazard_ctrl_pkg;

    localparam int WB_W        = 2;
    localparam int M_W         = 3;
    localparam int EX_W        = 5;
    localparam int REG_W       = 5;
    localparam int MEMREAD_BIT = 1;

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_LDSTALL = 2'd1;
    localparam logic [1:0] ST_JFLUSH  = 2'd2;

    typedef enum logic [1:0] {
        RUN     = ST_RUN,
        LDSTALL = ST_LDSTALL,
        JFLUSH  = ST_JFLUSH
    } hz_state_e;

endpackage : id_hazard_ctrl_pkg

// File: rtl/id_hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// id_hazard_ctrl_if
// Bundle between the ID-stage decoder / ID/EX register and the hazard
// controller.
//   master : the ID-stage side; drives decoded control, IF/ID register fields
//            and the ID/EX feedback, receives the gated bundle and enables.
//   slave  : the hazard controller.
// Signals:
//   WB1/M1/EX/jump_in      decoded control from ID
//   idRs/idRt/idUsesRt     source operands of the instruction in ID
//   exMemRead/exRt/exJump  ID/EX registered MemRead, rt, jump
//   WB1_o/M1_o/EX_o/jump_o gated control into ID/EX
//   pc_write/ifid_write    PC and IF/ID load enables
//   ifid_flush             IF/ID clear to NOP
//   bubble                 the ID/EX input this cycle is a bubble
//   state_dbg              current hazard FSM state (see id_hazard_ctrl_pkg)
// Handshake: there is no valid/ready pairing here; every signal is a
// level that is valid in every cycle, and the gated outputs are combinational
// from the inputs and the registered FSM state within the same cycle.
// -----------------------------------------------------------------------------
interface id_hazard_ctrl_if;
    import id_hazard_ctrl_pkg::*;

    logic [WB_W-1:0]  WB1;
    logic [M_W-1:0]   M1;
    logic [EX_W-1:0]  EX;
    logic             jump_in;
    logic [REG_W-1:0] idRs;
    logic [REG_W-1:0] idRt;
    logic             idUsesRt;
    logic             exMemRead;
    logic [REG_W-1:0] exRt;
    logic             exJump;

    logic [WB_W-1:0]  WB1_o;
    logic [M_W-1:0]   M1_o;
    logic [EX_W-1:0]  EX_o;
    logic             jump_o;
    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
    logic             bubble;
    logic [1:0]       state_dbg;

    modport master (
        output WB1, M1, EX, jump_in, idRs, idRt, idUsesRt,
               exMemRead, exRt, exJump,
        input  WB1_o, M1_o, EX_o, jump_o, pc_write, ifid_write,
               ifid_flush, bubble, state_dbg
    );

    modport slave (
        input  WB1, M1, EX, jump_in, idRs, idRt, idUsesRt,
               exMemRead, exRt, exJump,
        output WB1_o, M1_o, EX_o, jump_o, pc_write, ifid_write,
               ifid_flush, bubble, state_dbg
    );

endinterface : id_hazard_ctrl_if

// File: rtl/id_hazard_ctrl_hz_detect.sv
// -----------------------------------------------------------------------------
// hz_detect
// Purely combinational load-use comparator.
//   exMemRead, exRt : load currently in ID/EX and its destination rt
//   idRs, idRt      : source operands of the instruction in ID
//   idUsesRt        : the ID instruction actually reads rt
//   hz              : the ID instruction needs a value the load has not
//                     produced yet
// -----------------------------------------------------------------------------
module hz_detect
    import id_hazard_ctrl_pkg::*;
(
    input  logic             exMemRead,
    input  logic [REG_W-1:0] exRt,
    input  logic [REG_W-1:0] idRs,
    input  logic [REG_W-1:0] idRt,
    input  logic             idUsesRt,
    output logic             hz
);

    logic rs_match;
    logic rt_match;

    // $zero is never a real destination, so it can never create a hazard.
    assign rs_match = (exRt == idRs);
    assign rt_match = idUsesRt && (exRt == idRt);
    assign hz       = exMemRead && (exRt != '0) && (rs_match || rt_match);

endmodule : hz_detect

// File: rtl/id_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// id_hazard_ctrl
// Decode-stage hazard controller on the write side of the ID/EX register.
// Turns the ID control bundle into bubbles, holds PC and IF/ID on load-use
// hazards, and flushes IF/ID for jumps resolved in EX. A small FSM stretches
// stalls and flushes to LOAD_STALL_CYCLES / JUMP_BUBBLES cycles.
// Ports:
//   clkHZ      rising-edge clock
//   rstHZ      asynchronous active-high reset; while high the block drives
//              a bubble, holds PC/IF/ID and requests an IF/ID flush
//   hz_if      id_hazard_ctrl_if.slave (control in, gated control out)
//   stall_cnt  (HAZ_STATS_EN only) saturating count of cycles with
//              pc_write=0 outside reset
//   flush_cnt  (HAZ_STATS_EN only) saturating count of cycles with
//              ifid_flush=1 outside reset
// Parameters:
//   LOAD_STALL_CYCLES  hold cycles per load-use hazard (1..7)
//   JUMP_BUBBLES       flush cycles per taken jump (1..3)
// Optional feature macro: HAZ_STATS_EN.
// -----------------------------------------------------------------------------
module id_hazard_ctrl
    import id_hazard_ctrl_pkg::*;
#(
    parameter int unsigned LOAD_STALL_CYCLES = 1,
    parameter int unsigned JUMP_BUBBLES      = 1
) (
    input  logic            clkHZ,
    input  logic            rstHZ,
`ifdef HAZ_STATS_EN
    output logic [15:0]     stall_cnt,
    output logic [15:0]     flush_cnt,
`endif
    id_hazard_ctrl_if.slave hz_if
);

    // The cycle that enters a stall/flush is itself the first of the run,
    // so the counter is loaded with the remaining cycles.
    localparam logic [2:0] LS_LOAD = 3'(LOAD_STALL_CYCLES - 1);
    localparam logic [2:0] JB_LOAD = 3'(JUMP_BUBBLES - 1);

    logic [1:0] state_q, state_d;
    logic [2:0] cnt_q,   cnt_d;

    logic hz;
    logic do_bubble;
    logic do_hold;
    logic do_flush;

    hz_detect u_hz_detect (
        .exMemRead (hz_if.exMemRead),
        .exRt      (hz_if.exRt),
        .idRs      (hz_if.idRs),
        .idRt      (hz_if.idRt),
        .idUsesRt  (hz_if.idUsesRt),
        .hz        (hz)
    );

    // Priority: ongoing jump flush, then a new jump (which also aborts a load
    // stall), then an ongoing load stall, then a fresh hazard. During a flush
    // the IF/ID contents are being discarded, so hz is deliberately ignored.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        do_bubble = 1'b0;
        do_hold   = 1'b0;
        do_flush  = 1'b0;

        if (state_q == ST_JFLUSH) begin
            do_bubble = 1'b1;
            do_flush  = 1'b1;
            cnt_d     = cnt_q - 3'd1;
            if (cnt_q <= 3'd1) begin
                state_d = ST_RUN;
                cnt_d   = 3'd0;
            end
        end else if (hz_if.exJump) begin
            do_bubble = 1'b1;
            do_flush  = 1'b1;
            if (JUMP_BUBBLES > 1) begin
                state_d = ST_JFLUSH;
                cnt_d   = JB_LOAD;
            end else begin
                state_d = ST_RUN;
                cnt_d   = 3'd0;
            end
        end else if (state_q == ST_LDSTALL) begin
            do_bubble = 1'b1;
            do_hold   = 1'b1;
            cnt_d     = cnt_q - 3'd1;
            if (cnt_q <= 3'd1) begin
                state_d = ST_RUN;
                cnt_d   = 3'd0;
            end
        end else if (hz) begin
            do_bubble = 1'b1;
            do_hold   = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
                state_d = ST_LDSTALL;
                cnt_d   = LS_LOAD;
            end
        end
    end

    // Reset overrides everything combinationally so the pipeline is frozen
    // and flushed for as long as rstHZ is high, not just from the next edge.
    always_comb begin
        if (rstHZ) begin
            hz_if.WB1_o      = '0;
            hz_if.M1_o       = '0;
            hz_if.EX_o       = '0;
            hz_if.jump_o     = 1'b0;
            hz_if.bubble     = 1'b1;
            hz_if.pc_write   = 1'b0;
            hz_if.ifid_write = 1'b0;
            hz_if.ifid_flush = 1'b1;
        end else begin
            hz_if.WB1_o      = do_bubble ? '0   : hz_if.WB1;
            hz_if.M1_o       = do_bubble ? '0   : hz_if.M1;
            hz_if.EX_o       = do_bubble ? '0   : hz_if.EX;
            hz_if.jump_o     = do_bubble ? 1'b0 : hz_if.jump_in;
            hz_if.bubble     = do_bubble;
            hz_if.pc_write   = !do_hold;
            hz_if.ifid_write = !do_hold;
            hz_if.ifid_flush = do_flush;
        end
    end

    assign hz_if.state_dbg = state_q;

    always_ff @(posedge clkHZ or posedge rstHZ) begin
        if (rstHZ) begin
            state_q <= ST_RUN;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef HAZ_STATS_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!hz_if.pc_write && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
        if (hz_if.ifid_flush && (flush_cnt_q != 16'hFFFF)) begin
            flush_cnt_d = flush_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clkHZ or posedge rstHZ) begin
        if (rstHZ) begin
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule : id_hazard_ctrl

// File: doc/id_hazard_ctrl.md
# id_hazard_ctrl

Decode-stage hazard controller on the write side of the ID/EX pipeline register. It sits between the ID-stage control decoder and the ID/EX register. It gates the WB/MEM/EX/jump control bundle into bubbles, and holds the PC and IF/ID on load-use hazards. It also flushes IF/ID on a jump resolved in EX. A small FSM extends stalls and flushes over configurable cycle counts.

## Interface
Parameters:
- LOAD_STALL_CYCLES, 1, bubble/hold cycles per load-use hazard (1..7)
- JUMP_BUBBLES, 1, flush/bubble cycles per taken jump (1..3)

Ports:
- clkHZ  in  1  clock, rising edge
- rstHZ  in  1  reset, asynchronous, active-high
- WB1  in  2  decoded WB control from ID
- M1  in  3  decoded MEM control; M1[1] = MemRead
- EX  in  5  decoded EX control {ALUSrc, ALUOp[2:0], RegDst}
- jump_in  in  1  decoded jump from ID
- idRs  in  5  IF/ID instruction[25:21]
- idRt  in  5  IF/ID instruction[20:16]
- idUsesRt  in  1  ID instruction reads rt (R-type, store, branch)
- exMemRead  in  1  ID/EX registered MemRead (Mem1[1])
- exRt  in  5  ID/EX registered rt field
- exJump  in  1  ID/EX registered jump_out
- WB1_o  out  2  gated WB control to ID/EX
- M1_o  out  3  gated MEM control to ID/EX
- EX_o  out  5  gated EX control to ID/EX
- jump_o  out  1  gated jump to ID/EX
- pc_write  out  1  PC load enable
- ifid_write  out  1  IF/ID load enable
- ifid_flush  out  1  IF/ID clear to NOP
- bubble  out  1  current ID/EX input is a bubble

## Operation
- Load-use hazard (comb.): hz = exMemRead & (exRt != 0) & ((exRt == idRs) | (idUsesRt & (exRt == idRt))).
- Bubble: WB1_o, M1_o, EX_o, jump_o forced to 0 and bubble=1. Otherwise the inputs pass through and bubble=0.
- FSM states RUN, LDSTALL, JFLUSH, with a 3-bit down-counter cnt.
- RUN:
  - exJump=1: bubble, ifid_flush=1, pc_write=1, ifid_write=1. If JUMP_BUBBLES>1, go to JFLUSH with cnt=JUMP_BUBBLES-1.
  - Else if hz=1: bubble, pc_write=0, ifid_write=0. If LOAD_STALL_CYCLES>1, go to LDSTALL with cnt=LOAD_STALL_CYCLES-1.
  - Else: pass-through, pc_write=1, ifid_write=1, ifid_flush=0.
- LDSTALL:
  - Bubble, pc_write=0, ifid_write=0. Decrement cnt each cycle; on the cycle where cnt==1, the next state is RUN.
  - exJump=1 overrides the stall: behave as the RUN jump case and abort the stall.
- JFLUSH:
  - Bubble, ifid_flush=1, pc_write=1, ifid_write=1. Decrement cnt; when cnt==1, go to RUN.
  - hz is ignored, because IF/ID content is being discarded.
- Priority: exJump > LDSTALL hold > hz > pass-through.

## Timing
- All gating outputs are combinational from the inputs, state and cnt; there is zero added latency into ID/EX.
- State and cnt update on the rising clkHZ edge.
- A single-cycle hazard (default parameters) never leaves RUN.
- Reset (async assert, applies immediately):
  - state=RUN, cnt=0.
  - While rstHZ=1: WB1_o, M1_o, EX_o, jump_o = 0; bubble=1; pc_write=0; ifid_write=0; ifid_flush=1.
- Reset deasserted mid-stall or mid-flush: the block resumes in RUN with no residual hold.
- exRt==0 never stalls. hz and exJump together: the flush takes precedence and there is no hold.

## Configuration
- HAZ_STATS_EN defined:
  - Adds output stall_cnt [15:0], counting cycles with pc_write=0 outside reset.
  - Adds output flush_cnt [15:0], counting cycles with ifid_flush=1 outside reset.
  - Both counters saturate at 16'hFFFF and are cleared by rstHZ.
- HAZ_STATS_EN undefined: neither port nor counter exists, and behaviour is otherwise identical.

## Structure
- Shared pipeline package holds:
  - width constants WB_W=2, M_W=3, EX_W=5, REG_W=5
  - MEMREAD_BIT=1
  - the state enum {RUN, LDSTALL, JFLUSH}
- The ID/EX register consumes the *_o outputs unchanged.
- One sub-module, hz_detect: the purely combinational comparator producing hz.

## Test plan
- lw writing exRt=5 with exMemRead=1, next instruction idRs=5 -> one cycle with bubble=1, pc_write=0, ifid_write=0, all *_o=0; the following cycle passes through.
- exRt=0, exMemRead=1, idRs=0 -> no stall; WB1=2'b10 appears on WB1_o the same cycle.
- idRt=7 match with idUsesRt=0 -> no stall; the same case with idUsesRt=1 -> stall.
- JUMP_BUBBLES=2, exJump=1 for one cycle -> ifid_flush=1 for 2 cycles, pc_write=1 throughout, bubble=1 for 2 cycles.
- LOAD_STALL_CYCLES=3, hz at cycle 0, exJump=1 at cycle 1 -> stall aborts at cycle 1, ifid_flush=1, pc_write=1.
- rstHZ asserted during LDSTALL -> outputs take their reset values immediately; after deassert, RUN pass-through. With HAZ_STATS_EN, stall_cnt reads 0.
